// File: rtl/proc_hier_pkg.sv
// Shared constants and the trace bundle for the processor-hierarchy monitor.
`default_nettype none

package proc_hier_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int REG_IDX_W = 3;
    localparam int DATA_W    = 16;

    typedef struct packed {
        logic                 reg_write;
        logic [REG_IDX_W-1:0] write_reg;
        logic [DATA_W-1:0]    write_data;
        logic                 mem_read;
        logic                 mem_write;
        logic [DATA_W-1:0]    mem_addr;
        logic [DATA_W-1:0]    mem_data_in;
        logic [DATA_W-1:0]    mem_data_out;
        logic                 halt;
    } trace_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low reset and synchronous clear.
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/proc_hier_mon.sv
// Trace/perf-monitor shell: combinational trace taps plus counters frozen on halt.
// Optional feature macro: CACHE_STATS_EN builds the four cache event counters.
`default_nettype none

module proc_hier_mon
    import proc_hier_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_en_mem_wb,
    input  logic [REG_IDX_W-1:0] w1_reg_mem_wb,
    input  logic [DATA_W-1:0]    writedata_mem_wb,
    input  logic                 mem_en_ex_mem,
    input  logic                 mem_wr_ex_mem,
    input  logic [DATA_W-1:0]    alu_out_ex_mem,
    input  logic [DATA_W-1:0]    dmem_in,
    input  logic [DATA_W-1:0]    dmem_out,
    input  logic                 halt_ex_mem,
    input  logic                 icache_req,
    input  logic                 icache_hit,
    input  logic                 dcache_req,
    input  logic                 dcache_hit,
    output logic                 reg_write,
    output logic [REG_IDX_W-1:0] write_reg,
    output logic [DATA_W-1:0]    write_data,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [DATA_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_data_in,
    output logic [DATA_W-1:0]    mem_data_out,
    output logic                 halt,
    output logic                 halted,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     inst_count,
    output logic [CNT_W-1:0]     ic_req_count,
    output logic [CNT_W-1:0]     ic_hit_count,
    output logic [CNT_W-1:0]     dc_req_count,
    output logic [CNT_W-1:0]     dc_hit_count
);

    trace_t trace;
    logic   cnt_en;
    logic   retire;

    always_comb begin
        trace              = '0;
        trace.reg_write    = reg_en_mem_wb;
        trace.write_reg    = w1_reg_mem_wb;
        trace.write_data   = writedata_mem_wb;
        trace.mem_read     = mem_en_ex_mem & ~mem_wr_ex_mem;
        trace.mem_write    = mem_en_ex_mem & mem_wr_ex_mem;
        trace.mem_addr     = alu_out_ex_mem;
        trace.mem_data_in  = dmem_in;
        trace.mem_data_out = dmem_out;
        trace.halt         = halt_ex_mem;
    end

    assign reg_write    = trace.reg_write;
    assign write_reg    = trace.write_reg;
    assign write_data   = trace.write_data;
    assign mem_read     = trace.mem_read;
    assign mem_write    = trace.mem_write;
    assign mem_addr     = trace.mem_addr;
    assign mem_data_in  = trace.mem_data_in;
    assign mem_data_out = trace.mem_data_out;
    assign halt         = trace.halt;

    // Async reset is already handled inside each flop, so only halt gates counting.
    assign cnt_en = ~halted;
    assign retire = trace.halt | trace.reg_write | trace.mem_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (halt_ex_mem) begin
            halted <= 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(cnt_en), .q(cycle_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_inst_cnt (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(cnt_en & retire), .q(inst_count)
    );

`ifdef CACHE_STATS_EN
    if (1) begin : g_cache_stats
        // A hit strobe without a matching request is not a real lookup.
        sat_counter #(.CNT_W(CNT_W)) u_ic_req_cnt (
            .clk(clk), .rst(rst), .clr(1'b0), .inc(cnt_en & icache_req), .q(ic_req_count)
        );
        sat_counter #(.CNT_W(CNT_W)) u_ic_hit_cnt (
            .clk(clk), .rst(rst), .clr(1'b0), .inc(cnt_en & icache_req & icache_hit),
            .q(ic_hit_count)
        );
        sat_counter #(.CNT_W(CNT_W)) u_dc_req_cnt (
            .clk(clk), .rst(rst), .clr(1'b0), .inc(cnt_en & dcache_req), .q(dc_req_count)
        );
        sat_counter #(.CNT_W(CNT_W)) u_dc_hit_cnt (
            .clk(clk), .rst(rst), .clr(1'b0), .inc(cnt_en & dcache_req & dcache_hit),
            .q(dc_hit_count)
        );
    end
`else
    if (1) begin : g_no_cache_stats
        logic unused_cache;
        assign unused_cache = &{1'b0, icache_req, icache_hit, dcache_req, dcache_hit};
        assign ic_req_count = '0;
        assign ic_hit_count = '0;
        assign dc_req_count = '0;
        assign dc_hit_count = '0;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_proc_hier_mon.sv
// Self-checking bench for proc_hier_mon: table vectors, directed corners, random vs. model.
`default_nettype none

module tb_proc_hier_mon;

`ifdef CACHE_STATS_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_en_mem_wb = 0, mem_en_ex_mem = 0, mem_wr_ex_mem = 0, halt_ex_mem = 0;
    logic [2:0]  w1_reg_mem_wb = 0;
    logic [15:0] writedata_mem_wb = 0, alu_out_ex_mem = 0, dmem_in = 0, dmem_out = 0;
    logic        icache_req = 0, icache_hit = 0, dcache_req = 0, dcache_hit = 0;

    logic        reg_write, mem_read, mem_write, halt, halted;
    logic [2:0]  write_reg;
    logic [15:0] write_data, mem_addr, mem_data_in, mem_data_out;
    logic [31:0] cycle_count, inst_count, ic_req_count, ic_hit_count, dc_req_count, dc_hit_count;

    logic        s_reg_write, s_mem_read, s_mem_write, s_halt, s_halted;
    logic [2:0]  s_write_reg;
    logic [15:0] s_write_data, s_mem_addr, s_mem_data_in, s_mem_data_out;
    logic [3:0]  s_cycle, s_inst, s_icr, s_ich, s_dcr, s_dch;

    always #5 clk = ~clk;

    proc_hier_mon u_dut (
        .clk(clk), .rst(rst), .reg_en_mem_wb(reg_en_mem_wb), .w1_reg_mem_wb(w1_reg_mem_wb),
        .writedata_mem_wb(writedata_mem_wb), .mem_en_ex_mem(mem_en_ex_mem),
        .mem_wr_ex_mem(mem_wr_ex_mem), .alu_out_ex_mem(alu_out_ex_mem), .dmem_in(dmem_in),
        .dmem_out(dmem_out), .halt_ex_mem(halt_ex_mem), .icache_req(icache_req),
        .icache_hit(icache_hit), .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .halt(halt), .halted(halted),
        .cycle_count(cycle_count), .inst_count(inst_count), .ic_req_count(ic_req_count),
        .ic_hit_count(ic_hit_count), .dc_req_count(dc_req_count), .dc_hit_count(dc_hit_count)
    );

    proc_hier_mon #(.CNT_W(4)) u_small (
        .clk(clk), .rst(rst), .reg_en_mem_wb(reg_en_mem_wb), .w1_reg_mem_wb(w1_reg_mem_wb),
        .writedata_mem_wb(writedata_mem_wb), .mem_en_ex_mem(mem_en_ex_mem),
        .mem_wr_ex_mem(mem_wr_ex_mem), .alu_out_ex_mem(alu_out_ex_mem), .dmem_in(dmem_in),
        .dmem_out(dmem_out), .halt_ex_mem(halt_ex_mem), .icache_req(icache_req),
        .icache_hit(icache_hit), .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .reg_write(s_reg_write), .write_reg(s_write_reg), .write_data(s_write_data),
        .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_addr(s_mem_addr),
        .mem_data_in(s_mem_data_in), .mem_data_out(s_mem_data_out), .halt(s_halt),
        .halted(s_halted), .cycle_count(s_cycle), .inst_count(s_inst), .ic_req_count(s_icr),
        .ic_hit_count(s_ich), .dc_req_count(s_dcr), .dc_hit_count(s_dch)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: unbounded event tallies, saturated only when compared.
    longint unsigned m_cycle, m_inst, m_icr, m_ich, m_dcr, m_dch;
    bit              m_halted;

    function automatic logic [63:0] sat(longint unsigned v, int w);
        longint unsigned lim = (64'd1 << w) - 64'd1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cycle = 0; m_inst = 0; m_icr = 0; m_ich = 0; m_dcr = 0; m_dch = 0;
        m_halted = 0;
    endtask

    task automatic model_edge();
        if (rst && !m_halted) begin
            m_cycle++;
            if (halt_ex_mem || reg_en_mem_wb || (mem_en_ex_mem && mem_wr_ex_mem)) m_inst++;
            if (icache_req) m_icr++;
            if (icache_req && icache_hit) m_ich++;
            if (dcache_req) m_dcr++;
            if (dcache_req && dcache_hit) m_dch++;
            if (halt_ex_mem) m_halted = 1;
        end
    endtask

    task automatic check_all();
        check("halted", 64'(halted), 64'(m_halted));
        check("cycle", 64'(cycle_count), sat(m_cycle, 32));
        check("inst", 64'(inst_count), sat(m_inst, 32));
        check("ic_req", 64'(ic_req_count), CACHE_ON ? sat(m_icr, 32) : 64'd0);
        check("ic_hit", 64'(ic_hit_count), CACHE_ON ? sat(m_ich, 32) : 64'd0);
        check("dc_req", 64'(dc_req_count), CACHE_ON ? sat(m_dcr, 32) : 64'd0);
        check("dc_hit", 64'(dc_hit_count), CACHE_ON ? sat(m_dch, 32) : 64'd0);
        check("s_cycle", 64'(s_cycle), sat(m_cycle, 4));
        check("s_inst", 64'(s_inst), sat(m_inst, 4));
        check("s_ic_hit", 64'(s_ich), CACHE_ON ? sat(m_ich, 4) : 64'd0);
        check("s_dc_req", 64'(s_dcr), CACHE_ON ? sat(m_dcr, 4) : 64'd0);
        check("mem_read", 64'(mem_read), 64'(mem_en_ex_mem && !mem_wr_ex_mem));
        check("mem_write", 64'(mem_write), 64'(mem_en_ex_mem && mem_wr_ex_mem));
        check("trace_data", {mem_addr, mem_data_in, mem_data_out, write_data},
              {alu_out_ex_mem, dmem_in, dmem_out, writedata_mem_wb});
        check("trace_ctl", {61'd0, reg_write, halt, 1'b0} | 64'(write_reg) << 8,
              {61'd0, reg_en_mem_wb, halt_ex_mem, 1'b0} | 64'(w1_reg_mem_wb) << 8);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rand_inputs(bit allow_halt);
        reg_en_mem_wb    = 1'($urandom);
        w1_reg_mem_wb    = 3'($urandom);
        writedata_mem_wb = 16'($urandom);
        mem_en_ex_mem    = 1'($urandom);
        mem_wr_ex_mem    = 1'($urandom);
        alu_out_ex_mem   = 16'($urandom);
        dmem_in          = 16'($urandom);
        dmem_out         = 16'($urandom);
        halt_ex_mem      = allow_halt ? ($urandom_range(0, 3) == 0) : 1'b0;
        icache_req       = 1'($urandom);
        icache_hit       = 1'($urandom);
        dcache_req       = 1'($urandom);
        dcache_hit       = 1'($urandom);
    endtask

    task automatic idle_inputs();
        reg_en_mem_wb = 0; mem_en_ex_mem = 0; mem_wr_ex_mem = 0; halt_ex_mem = 0;
        icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
    endtask

    typedef struct {
        logic        mem_en, mem_wr, reg_en;
        logic [15:0] addr;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        logic        exp_rd, exp_wr;
        int          exp_inc;
    } vec_t;

    vec_t vecs[6];
    longint unsigned base, base_r, base_h;

    initial begin
        vecs[0] = '{1, 0, 0, 16'h0040, 3'd0, 16'h0000, 1, 0, 0};
        vecs[1] = '{1, 1, 0, 16'h0040, 3'd0, 16'h0000, 0, 1, 1};
        vecs[2] = '{0, 1, 0, 16'h1234, 3'd1, 16'h0001, 0, 0, 0};
        vecs[3] = '{0, 0, 1, 16'h0000, 3'd5, 16'hBEEF, 0, 0, 1};
        vecs[4] = '{1, 1, 1, 16'hFFFF, 3'd7, 16'h5A5A, 0, 1, 1};
        vecs[5] = '{1, 0, 1, 16'h8000, 3'd2, 16'h0F0F, 1, 0, 1};

        // Reset held for 3 cycles, then 5 idle cycles.
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        repeat (5) step();
        check("idle_cycle5", 64'(cycle_count), 64'd5);
        check("idle_inst0", 64'(inst_count), 64'd0);

        // Trace decode and retire rule, one table row per cycle.
        foreach (vecs[i]) begin
            mem_en_ex_mem = vecs[i].mem_en; mem_wr_ex_mem = vecs[i].mem_wr;
            reg_en_mem_wb = vecs[i].reg_en; alu_out_ex_mem = vecs[i].addr;
            w1_reg_mem_wb = vecs[i].wreg;   writedata_mem_wb = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rd", i), 64'(mem_read), 64'(vecs[i].exp_rd));
            check($sformatf("vec%0d_wr", i), 64'(mem_write), 64'(vecs[i].exp_wr));
            check($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(vecs[i].addr));
            base = m_inst;
            step();
            check($sformatf("vec%0d_inst", i), 64'(inst_count), base + 64'(vecs[i].exp_inc));
        end
        idle_inputs();

        // Four register writebacks retire four instructions.
        reg_en_mem_wb = 1; w1_reg_mem_wb = 3'd5; writedata_mem_wb = 16'hBEEF;
        base = m_inst;
        repeat (4) begin
            step();
            check("rw_reg", {60'd0, reg_write, write_reg}, {60'd0, 1'b1, 3'd5});
            check("rw_data", 64'(write_data), 64'hBEEF);
        end
        check("rw_inst4", 64'(inst_count), base + 64'd4);
        idle_inputs();

        // 10 I-cache requests with 7 hits, then 2 orphan hits.
        base_r = CACHE_ON ? m_icr : 0;
        base_h = CACHE_ON ? m_ich : 0;
        for (int i = 0; i < 10; i++) begin
            icache_req = 1; icache_hit = (i < 7);
            step();
        end
        icache_req = 0; icache_hit = 1;
        repeat (2) step();
        check("ic_req10", 64'(ic_req_count), CACHE_ON ? base_r + 64'd10 : 64'd0);
        check("ic_hit7", 64'(ic_hit_count), CACHE_ON ? base_h + 64'd7 : 64'd0);
        idle_inputs();

        // Random traffic without halts; the 4-bit instance saturates on the way.
        for (int i = 0; i < 150; i++) begin
            rand_inputs(1'b0);
            step();
        end
        check("small_sat15", 64'(s_cycle), 64'd15);

        // Mid-cycle reset, then halt exactly on the 20th counted cycle.
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        rst = 1'b1;
        for (int i = 0; i < 19; i++) begin
            rand_inputs(1'b0);
            step();
        end
        rand_inputs(1'b0);
        halt_ex_mem = 1;
        base = m_inst;
        step();
        check("halt_cycle20", 64'(cycle_count), 64'd20);
        check("halt_retired", 64'(inst_count), base + 64'd1);
        check("halt_flag", 64'(halted), 64'd1);
        for (int i = 0; i < 10; i++) begin
            rand_inputs(1'b1);
            step();
        end
        check("frozen_cycle", 64'(cycle_count), 64'd20);

        // Reset while halted, away from any clock edge.
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_cycle0", 64'(cycle_count), 64'd0);
        check("async_halted0", 64'(halted), 64'd0);
        check_all();
        idle_inputs();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        repeat (3) step();
        check("resume_cycle3", 64'(cycle_count), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
